uart_rx_frame: RTL

- UART receive framer, directly downstream of the Rx oversampling baud generator.
- Consumes the generator's toggling BaudOut as an oversample tick and samples the asynchronous serial line at mid-bit.
- Assembles start/data/[parity]/stop frames and presents parallel bytes with a one-cycle valid strobe and error flags to the Rx buffer or host.

---
 rtl/uart_rx_frame_if.sv | 25 ++
 rtl/uart_rx_frame.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_if.sv
// Serial-line and parallel-result signals between the UART receive framer and its neighbours.
// The master side drives the line, baud tick and config; the slave side (the framer) returns bytes.
interface uart_rx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  BaudOut;
    logic                  OverSel;
    logic                  ParityType;
    logic                  RxIn;
    logic [DATA_WIDTH-1:0] RxData;
    logic                  RxValid;
    logic                  ParityError;
    logic                  FrameError;
    logic                  Busy;

    modport master (
        output BaudOut, OverSel, ParityType, RxIn,
        input  RxData, RxValid, ParityError, FrameError, Busy
    );

    modport slave (
        input  BaudOut, OverSel, ParityType, RxIn,
        output RxData, RxValid, ParityError, FrameError, Busy
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive framer: mid-bit sampling on BaudOut rising-edge ticks, LSB-first data, one-cycle RxValid.
// Define PARITY_EN to insert a parity bit between data and stop; otherwise ParityError is tied low.
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input logic            Clock,
    input logic            Reset,
    uart_rx_frame_if.slave Bus
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP
    } stateT;

    stateT                 state;
    stateT                 stateNext;
    logic                  sync1;
    logic                  rxS;
    logic                  baudPrev;
    logic                  tick;
    logic                  overL;
    logic [3:0]            tickCnt;
    logic [BW-1:0]         bitCnt;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [DATA_WIDTH-1:0] rxData;
    logic                  rxValid;
    logic                  frameErr;
    logic [3:0]            halfTick;
    logic [3:0]            lastTick;
    logic                  atHalf;
    logic                  atLast;
    logic                  lastBit;
    logic                  busy;

    assign tick     = Bus.BaudOut & ~baudPrev;
    assign halfTick = overL ? 4'd7 : 4'd3;
    assign lastTick = overL ? 4'd15 : 4'd7;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state logic; every transition is qualified by a tick, so no ticks means no movement.
    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        stateNext = state;
        case (state)
            IDLE:  if (tick && !rxS) stateNext = START;
            START: if (atHalf)       stateNext = rxS ? IDLE : DATA;
`ifdef PARITY_EN
            DATA:   if (atLast && lastBit) stateNext = PARITY;
            PARITY: if (atLast)            stateNext = STOP;
`else
            DATA:   if (atLast && lastBit) stateNext = STOP;
`endif
            STOP:  if (atLast)       stateNext = IDLE;
            default:                 stateNext = IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        atHalf  = tick && (tickCnt == halfTick);
        atLast  = tick && (tickCnt == lastTick);
        lastBit = (bitCnt == BW'(DATA_WIDTH - 1));
        busy    = (state != IDLE);
    end

`ifdef PARITY_EN
    logic parityTypeL;
    logic parityBit;
    logic parityErr;
`else
    logic unusedParityType;
    assign unusedParityType = Bus.ParityType;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            // NOTE: every register, shift register included, is cleared so an aborted frame leaves nothing behind.
            sync1    <= 1'b1;
            rxS      <= 1'b1;
            baudPrev <= 1'b0;
            overL    <= 1'b0;
            tickCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            rxData   <= '0;
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
`ifdef PARITY_EN
            parityTypeL <= 1'b0;
            parityBit   <= 1'b0;
            parityErr   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking everywhere so every register sees pre-edge values of its neighbours.
            sync1    <= Bus.RxIn;
            rxS      <= sync1;
            baudPrev <= Bus.BaudOut;
            rxValid  <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rxS) begin
                            overL   <= Bus.OverSel;
`ifdef PARITY_EN
                            parityTypeL <= Bus.ParityType;
`endif
                            tickCnt <= '0;
                        end
                    end
                    START: begin
                        if (tickCnt == halfTick) begin
                            tickCnt <= '0;
                            bitCnt  <= '0;
                        end else begin
                            tickCnt <= tickCnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (tickCnt == lastTick) begin
                            shiftReg <= {rxS, shiftReg[DATA_WIDTH-1:1]};
                            tickCnt  <= '0;
                            bitCnt   <= lastBit ? '0 : bitCnt + 1'b1;
                        end else begin
                            tickCnt <= tickCnt + 4'd1;
                        end
                    end
`ifdef PARITY_EN
                    PARITY: begin
                        if (tickCnt == lastTick) begin
                            parityBit <= rxS;
                            tickCnt   <= '0;
                        end else begin
                            tickCnt <= tickCnt + 4'd1;
                        end
                    end
`endif
                    STOP: begin
                        if (tickCnt == lastTick) begin
                            rxData   <= shiftReg;
                            frameErr <= ~rxS;
`ifdef PARITY_EN
                            parityErr <= parityBit != ((^shiftReg) ^ parityTypeL);
`endif
                            rxValid  <= 1'b1;
                            tickCnt  <= '0;
                        end else begin
                            tickCnt <= tickCnt + 4'd1;
                        end
                    end
                    default: tickCnt <= '0;
                endcase
            end
        end
    end

    assign Bus.RxData     = rxData;
    assign Bus.RxValid    = rxValid;
    assign Bus.FrameError = frameErr;
    assign Bus.Busy       = busy;
`ifdef PARITY_EN
    assign Bus.ParityError = parityErr;
`else
    assign Bus.ParityError = 1'b0;
`endif
endmodule
